// File: rtl/tlul_pkg.sv
// Shared TL-UL constants and the host FSM state type.
package tlul_pkg;

  localparam logic [2:0] PUT_FULL  = 3'd0;
  localparam logic [2:0] GET       = 3'd4;
  localparam logic [2:0] ACK       = 3'd0;
  localparam logic [2:0] ACK_DATA  = 3'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [3:0] MASK_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  // D opcode a well-behaved device returns for the given A request kind.
  function automatic logic [2:0] exp_d_opcode(input logic write);
    return write ? ACK : ACK_DATA;
  endfunction

endpackage

// File: rtl/tlul_timeout_cnt.sv
// Response watchdog: counts enabled cycles since clear, flags the LIMIT-th one.
module tlul_timeout_cnt
  import tlul_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] cnt_q, cnt_d;

  // Expired during the LIMIT-th enabled cycle after a clear.
  assign o_expired = i_enable && (cnt_q == 8'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !o_expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tlul_master_leds.sv
// TL-UL host with a single outstanding transaction, driving the LED slave.
module tlul_master_leds
  import tlul_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int SRC_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [31:0]       i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_error,
  output logic              o_a_valid,
  output logic [2:0]        o_a_opcode,
  output logic [2:0]        o_a_param,
  output logic [1:0]        o_a_size,
  output logic [SRC_W-1:0]  o_a_source,
  output logic [ADDR_W-1:0] o_a_address,
  output logic [3:0]        o_a_mask,
  output logic [31:0]       o_a_data,
  input  logic              i_a_ready,
  input  logic              i_d_valid,
  input  logic [2:0]        i_d_opcode,
  input  logic [SRC_W-1:0]  i_d_source,
  input  logic [31:0]       i_d_data,
  input  logic              i_d_error,
  output logic              o_d_ready
);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [SRC_W-1:0]    iss_src_q, iss_src_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_error_q, rsp_error_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;

  logic a_hs;
  logic d_match;
  logic d_err;
  logic tmo_expired;

  assign a_hs    = (state_q == REQ) && i_a_ready;
  assign d_match = i_d_valid && (i_d_source == iss_src_q);
  assign d_err   = i_d_error || (i_d_opcode != exp_d_opcode(write_q));

  tlul_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (a_hs),
    .i_enable  (state_q == WAIT_RSP),
    .o_expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    src_d       = src_q;
    iss_src_d   = iss_src_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    o_cmd_ready = 1'b0;
    o_a_valid   = 1'b0;
    o_d_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          write_d = i_cmd_write;
          addr_d  = i_cmd_addr & ~ADDR_W'(3);
          wdata_d = i_cmd_wdata;
          state_d = REQ;
        end
      end
      REQ: begin
        o_a_valid = 1'b1;
        if (i_a_ready) begin
          iss_src_d = src_q;
          src_d     = src_q + SRC_W'(1);
          state_d   = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        o_d_ready = 1'b1;
        // Non-matching beats are swallowed; a match wins over an expiring timer.
        if (d_match) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = d_err;
          rsp_rdata_d = (!write_q && !d_err) ? i_d_data : 32'd0;
          state_d     = IDLE;
        end else if (tmo_expired) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = 32'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      src_q       <= '0;
      iss_src_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      src_q       <= src_d;
      iss_src_q   <= iss_src_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // A fields read zero whenever no request is being presented.
  assign o_a_opcode  = o_a_valid ? (write_q ? PUT_FULL : GET) : 3'd0;
  assign o_a_param   = 3'd0;
  assign o_a_size    = o_a_valid ? SIZE_WORD : 2'd0;
  assign o_a_source  = o_a_valid ? src_q : '0;
  assign o_a_address = o_a_valid ? addr_q : '0;
  assign o_a_mask    = o_a_valid ? MASK_FULL : 4'd0;
  assign o_a_data    = (o_a_valid && write_q) ? wdata_q : 32'd0;

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_error = rsp_error_q;
  assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_tlul_master_leds.sv
// Directed bench for the TL-UL host: A-channel fields, responses, timeout, reset.
module tb_tlul_master_leds;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_write = 1'b0;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_error;
  logic        o_a_valid;
  logic [2:0]  o_a_opcode;
  logic [2:0]  o_a_param;
  logic [1:0]  o_a_size;
  logic [3:0]  o_a_source;
  logic [31:0] o_a_address;
  logic [3:0]  o_a_mask;
  logic [31:0] o_a_data;
  logic        i_a_ready = 1'b0;
  logic        i_d_valid = 1'b0;
  logic [2:0]  i_d_opcode = '0;
  logic [3:0]  i_d_source = '0;
  logic [31:0] i_d_data = '0;
  logic        i_d_error = 1'b0;
  logic        o_d_ready;

  int checks = 0;
  int errors = 0;

  tlul_master_leds #(
    .ADDR_W(32), .SRC_W(4), .TIMEOUT(255)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_error(o_rsp_error),
    .o_a_valid(o_a_valid), .o_a_opcode(o_a_opcode), .o_a_param(o_a_param),
    .o_a_size(o_a_size), .o_a_source(o_a_source), .o_a_address(o_a_address),
    .o_a_mask(o_a_mask), .o_a_data(o_a_data), .i_a_ready(i_a_ready),
    .i_d_valid(i_d_valid), .i_d_opcode(i_d_opcode), .i_d_source(i_d_source),
    .i_d_data(i_d_data), .i_d_error(i_d_error), .o_d_ready(o_d_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge i_clk);
  endtask

  // Present a command in IDLE; returns at the negedge of the first REQ cycle.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = wd;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic d_beat(input logic [3:0] src, input logic [2:0] op,
                        input logic [31:0] data, input logic err);
    i_d_valid  = 1'b1;
    i_d_source = src;
    i_d_opcode = op;
    i_d_data   = data;
    i_d_error  = err;
    tick();
    i_d_valid  = 1'b0;
    i_d_error  = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    tick();
    check_eq("rst_cmd_ready", o_cmd_ready, 1);
    check_eq("rst_a_valid",   o_a_valid, 0);
    check_eq("rst_d_ready",   o_d_ready, 0);
    check_eq("rst_rsp_valid", o_rsp_valid, 0);
    check_eq("rst_rsp_error", o_rsp_error, 0);
    check_eq("rst_rsp_rdata", o_rsp_rdata, 0);
    check_eq("rst_a_address", o_a_address, 0);
    check_eq("rst_a_mask",    o_a_mask, 0);
    i_reset_n = 1'b1;
    tick();

    // Write 0xA5 to 0x10, ack in first WAIT_RSP cycle
    i_a_ready = 1'b1;
    issue(1'b1, 32'h10, 32'hA5);
    check_eq("wr_a_valid",  o_a_valid, 1);
    check_eq("wr_opcode",   o_a_opcode, 0);
    check_eq("wr_address",  o_a_address, 32'h10);
    check_eq("wr_mask",     o_a_mask, 4'hF);
    check_eq("wr_data",     o_a_data, 32'hA5);
    check_eq("wr_size",     o_a_size, 2);
    check_eq("wr_param",    o_a_param, 0);
    check_eq("wr_source",   o_a_source, 0);
    check_eq("wr_cmd_ready", o_cmd_ready, 0);
    tick();
    check_eq("wr_d_ready",  o_d_ready, 1);
    check_eq("wr_a_valid_off", o_a_valid, 0);
    d_beat(4'd0, 3'd0, 32'hFFFF_FFFF, 1'b0);
    check_eq("wr_rsp_valid", o_rsp_valid, 1);
    check_eq("wr_rsp_error", o_rsp_error, 0);
    check_eq("wr_rsp_rdata", o_rsp_rdata, 0);
    check_eq("wr_idle",      o_cmd_ready, 1);
    tick();
    check_eq("wr_rsp_pulse", o_rsp_valid, 0);

    // Read 0x13 -> address aligned to 0x10, data 0x5A returned
    issue(1'b0, 32'h13, 32'h1234);
    check_eq("rd_opcode",  o_a_opcode, 4);
    check_eq("rd_address", o_a_address, 32'h10);
    check_eq("rd_data",    o_a_data, 0);
    check_eq("rd_source",  o_a_source, 1);
    tick();
    d_beat(4'd1, 3'd1, 32'h5A, 1'b0);
    check_eq("rd_rsp_valid", o_rsp_valid, 1);
    check_eq("rd_rsp_error", o_rsp_error, 0);
    check_eq("rd_rsp_rdata", o_rsp_rdata, 32'h5A);
    tick();
    check_eq("rd_rdata_hold", o_rsp_rdata, 32'h5A);

    // a_ready low for 5 cycles; fields stable; then wrong D opcode -> error
    i_a_ready = 1'b0;
    issue(1'b1, 32'h22, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("stall_a_valid%0d", i), o_a_valid, 1);
      check_eq($sformatf("stall_addr%0d", i),    o_a_address, 32'h20);
      check_eq($sformatf("stall_data%0d", i),    o_a_data, 32'h1234_5678);
      check_eq($sformatf("stall_src%0d", i),     o_a_source, 2);
      tick();
    end
    i_a_ready = 1'b1;
    tick();
    check_eq("stall_hs_once", o_a_valid, 0);
    check_eq("stall_wait",    o_d_ready, 1);
    d_beat(4'd2, 3'd1, 32'h0, 1'b0);
    check_eq("opc_mismatch_valid", o_rsp_valid, 1);
    check_eq("opc_mismatch_error", o_rsp_error, 1);
    tick();

    // Wrong-source beat discarded, matching beat carries d_error
    issue(1'b0, 32'h40, 32'h0);
    check_eq("src3_source", o_a_source, 3);
    tick();
    d_beat(4'd7, 3'd1, 32'h1111, 1'b0);
    check_eq("stale_no_rsp",  o_rsp_valid, 0);
    check_eq("stale_d_ready", o_d_ready, 1);
    d_beat(4'd3, 3'd1, 32'hDEAD, 1'b1);
    check_eq("derr_valid", o_rsp_valid, 1);
    check_eq("derr_error", o_rsp_error, 1);
    check_eq("derr_rdata", o_rsp_rdata, 0);
    tick();

    // No response: timeout after exactly 255 WAIT_RSP cycles
    issue(1'b0, 32'h44, 32'h0);
    tick();
    n = 0;
    for (int i = 0; i < 400 && !o_rsp_valid; i++) begin
      if (o_d_ready) n++;
      tick();
    end
    check_eq("tmo_fired",     o_rsp_valid, 1);
    check_eq("tmo_cycles",    n, 255);
    check_eq("tmo_error",     o_rsp_error, 1);
    check_eq("tmo_rdata",     o_rsp_rdata, 0);
    check_eq("tmo_idle",      o_cmd_ready, 1);
    tick();

    // Matching response in the timeout cycle wins
    issue(1'b0, 32'h48, 32'h0);
    check_eq("prio_source", o_a_source, 5);
    tick();
    for (int i = 0; i < 254; i++) tick();
    check_eq("prio_still_wait", o_d_ready, 1);
    d_beat(4'd5, 3'd1, 32'h77, 1'b0);
    check_eq("prio_valid", o_rsp_valid, 1);
    check_eq("prio_error", o_rsp_error, 0);
    check_eq("prio_rdata", o_rsp_rdata, 32'h77);
    tick();

    // Reset during WAIT_RSP, then a late D beat in IDLE
    issue(1'b1, 32'h50, 32'h9);
    check_eq("rstw_source", o_a_source, 6);
    tick();
    check_eq("rstw_wait", o_d_ready, 1);
    i_reset_n = 1'b0;
    tick();
    check_eq("rstw_no_rsp",  o_rsp_valid, 0);
    check_eq("rstw_d_ready", o_d_ready, 0);
    check_eq("rstw_rdata",   o_rsp_rdata, 0);
    i_reset_n = 1'b1;
    tick();
    d_beat(4'd6, 3'd0, 32'h0, 1'b0);
    check_eq("late_no_rsp0", o_rsp_valid, 0);
    tick();
    check_eq("late_no_rsp1", o_rsp_valid, 0);
    check_eq("late_idle",    o_cmd_ready, 1);
    issue(1'b1, 32'h54, 32'h3);
    check_eq("post_rst_source", o_a_source, 0);
    check_eq("post_rst_addr",   o_a_address, 32'h54);
    tick();
    d_beat(4'd0, 3'd0, 32'h0, 1'b0);
    check_eq("post_rst_rsp", o_rsp_valid, 1);
    check_eq("post_rst_err", o_rsp_error, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
